// File: rtl/load_store_unit_pkg.sv
// Shared RV32I memory-access definitions: funct3 width codes, LSU state
// encoding and the request legality check used at accept time.
package load_store_unit_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    WR       = 3'd3,
    RMW_RD   = 3'd4,
    RMW_DATA = 3'd5,
    DONE     = 3'd6
  } lsu_state_t;

  // True for misaligned accesses and for funct3 codes with no RV32I meaning.
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] lane);
    logic illegal;
    if (we) begin
      illegal = (funct3 > SW) ||
                (funct3 == SH && lane[0]) ||
                (funct3 == SW && lane != 2'b00);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 >= 3'd6) ||
                ((funct3 == LH || funct3 == LHU) && lane[0]) ||
                (funct3 == LW && lane != 2'b00);
    end
    return illegal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load from a read word,
// and merges byte/halfword store data into a read word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case/if leaves it unassigned and infers a latch.
  always_comb begin
    byte_sel = read_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? read_word[31:16] : read_word[15:0];
    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      default: load_data = read_word;
    endcase
  end

  always_comb begin
    merged_word = read_word;
    if (funct3[1:0] == SB[1:0]) begin
      merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
    end else if (funct3[1:0] == SH[1:0]) begin
      merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
    end else begin
      merged_word = store_data;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit in front of a word-only data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] DMEM_addr_o,
  output logic [31:0] DMEM_data_o,
  input  logic [31:0] DMEM_data_i,
  output logic        DMEM_read_o,
  output logic        DMEM_write_o
);

  localparam logic [63:0] ADDR_MASK = (64'h1 << MEM_ADDR_WIDTH) - 64'h1;

  lsu_state_t  state, next_state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept  = (state == IDLE) && req_valid_i;
  assign req_err = req_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);

  lsu_align u_align (
    .funct3      (funct3_q),
    .lane        (addr_q[1:0]),
    .read_word   (DMEM_data_i),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err)              next_state = DONE;
          else if (!req_we_i)       next_state = RD_ISSUE;
          else if (req_funct3_i == SW) next_state = WR;
          else                      next_state = RMW_RD;
        end
      end
      RD_ISSUE: next_state = RD_DATA;
      RD_DATA:  next_state = DONE;
      RMW_RD:   next_state = RMW_DATA;
      RMW_DATA: next_state = WR;
      WR:       next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state != IDLE);
    done_o       = (state == DONE);
    err_o        = (state == DONE) && err_q;
    rdata_o      = rdata_q;
    DMEM_read_o  = (state == RD_ISSUE) || (state == RMW_RD);
    DMEM_write_o = (state == WR);
    DMEM_addr_o  = 32'h0;
    DMEM_data_o  = 32'h0;
    if (DMEM_read_o || DMEM_write_o) begin
      DMEM_addr_o = {addr_q[31:2], 2'b00} & ADDR_MASK[31:0];
    end
    if (DMEM_write_o) begin
      DMEM_data_o = wdata_q;
    end
  end

  // NOTE: every datapath register is reset so an aborted access leaves no
  // stale address or data visible; this block holds no memory arrays.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 32'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr_i;
        funct3_q <= req_funct3_i;
        we_q     <= req_we_i;
        wdata_q  <= req_wdata_i;
        err_q    <= req_err;
        if (req_err) rdata_q <= 32'h0;
      end
      if (state == RD_DATA && !we_q) rdata_q <= load_data;
      // Write register is reused to hold the merged word for the RMW write.
      if (state == RMW_DATA) wdata_q <= merged_word;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// scoreboard of expected completions built from an independent access model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'h0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o, DMEM_addr_o, DMEM_data_o, DMEM_data_i;
  logic        DMEM_read_o, DMEM_write_o;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .DMEM_addr_o  (DMEM_addr_o),
    .DMEM_data_o  (DMEM_data_o),
    .DMEM_data_i  (DMEM_data_i),
    .DMEM_read_o  (DMEM_read_o),
    .DMEM_write_o (DMEM_write_o)
  );

  logic [31:0] mem [0:255] = '{64: 32'h8BADF00D, default: 32'h0};
  logic [31:0] mem_rdata = 32'h0;

  always @(posedge clk) begin
    if (DMEM_write_o) mem[DMEM_addr_o[9:2]] <= DMEM_data_o;
    if (DMEM_read_o)  mem_rdata <= mem[DMEM_addr_o[9:2]];
  end
  assign DMEM_data_i = mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] word_addr;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          failed = 0;
  int          total = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        proto_bad = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  {31'h0, busy_o}, 32'h0);
    check({tag, "_done"},  {31'h0, done_o}, 32'h0);
    check({tag, "_err"},   {31'h0, err_o}, 32'h0);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_read"},  {31'h0, DMEM_read_o}, 32'h0);
    check({tag, "_write"}, {31'h0, DMEM_write_o}, 32'h0);
    check({tag, "_addr"},  DMEM_addr_o, 32'h0);
    check({tag, "_wdata"}, DMEM_data_o, 32'h0);
  endtask

  // Builds the expectation from the bench memory, drives one request, then
  // follows it to done_o while counting strobes; inject tries a request mid-flight.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit inject);
    exp_t        e, got;
    logic [31:0] word, sh, mask, s;
    int          n, rd, wr;
    logic [31:0] w_addr;

    word = mem[addr[9:2]];
    s    = {27'h0, addr[1:0], 3'b000};
    sh   = word >> s;
    if (we) e.err = (f3 > 3'd2) || (f3 == 3'd1 && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
    else    e.err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
                    ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
    e.word_addr = {addr[31:2], 2'b00};
    e.word      = word;
    e.rdata     = last_rdata;
    if (e.err) begin
      e.lat = 1; e.reads = 0; e.writes = 0; e.rdata = 32'h0;
    end else if (!we) begin
      e.lat = 3; e.reads = 1; e.writes = 0;
      case (f3)
        3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
        3'd4:    e.rdata = {24'h0, sh[7:0]};
        3'd1:    e.rdata = {{16{sh[15]}}, sh[15:0]};
        3'd5:    e.rdata = {16'h0, sh[15:0]};
        default: e.rdata = word;
      endcase
    end else begin
      mask     = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      e.word   = (word & ~(mask << s)) | ((wdata & mask) << s);
      e.writes = 1;
      e.lat    = (f3 == 3'd2) ? 2 : 4;
      e.reads  = (f3 == 3'd2) ? 0 : 1;
    end
    last_rdata = e.rdata;
    exp_q.push_back(e);

    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 1; rd = 0; wr = 0; w_addr = 32'h0;
    while (!done_o && n < 12) begin
      if (DMEM_read_o) rd++;
      if (DMEM_write_o) begin wr++; w_addr = DMEM_addr_o; end
      if (DMEM_read_o && DMEM_write_o) proto_bad = 1'b1;
      if (!DMEM_write_o && DMEM_data_o != 32'h0) proto_bad = 1'b1;
      if (inject && n == 1) begin
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2;
        req_addr_i = 32'h100; req_wdata_i = 32'hFFFF_FFFF;
      end else if (inject && n == 2) begin
        req_valid_i = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    got = exp_q.pop_front();
    check({name, "_done_seen"}, {31'h0, done_o}, 32'h1);
    check({name, "_latency"}, n, got.lat);
    check({name, "_err"}, {31'h0, err_o}, {31'h0, got.err});
    check({name, "_rdata"}, rdata_o, got.rdata);
    check({name, "_reads"}, rd, got.reads);
    check({name, "_writes"}, wr, got.writes);
    if (got.writes != 0) begin
      check({name, "_waddr"}, w_addr, got.word_addr);
      check({name, "_mem"}, mem[got.word_addr[9:2]], got.word);
    end
    @(posedge clk); #1;
    check({name, "_done_pulse"}, {31'h0, done_o}, 32'h0);
    check({name, "_idle"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    int w, d;

    #2;
    check_quiet("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_req("lb_103",  1'b0, 3'd0, 32'h103, 32'h0, 1'b1);
    run_req("lbu_102", 1'b0, 3'd4, 32'h102, 32'h0, 1'b0);
    run_req("lhu_102", 1'b0, 3'd5, 32'h102, 32'h0, 1'b0);
    run_req("lh_100",  1'b0, 3'd1, 32'h100, 32'h0, 1'b0);
    run_req("ld_f3_3", 1'b0, 3'd3, 32'h100, 32'h0, 1'b0);

    // Sub-word store aborted by reset while the merge is in progress.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd1;
    req_addr_i = 32'h100; req_wdata_i = 32'h0000_CAFE;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst_rmw_read", {31'h0, DMEM_read_o}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_quiet("rst_abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    w = 0; d = 0;
    for (int i = 0; i < 6; i++) begin
      if (DMEM_write_o) w++;
      if (done_o) d++;
      @(posedge clk); #1;
    end
    check("rst_no_write", w, 0);
    check("rst_no_done", d, 0);
    check("rst_mem", mem[64], 32'h8BADF00D);
    last_rdata = 32'h0;

    run_req("sb_101",  1'b1, 3'd0, 32'h101, 32'h1234_5677, 1'b0);
    run_req("lw_100",  1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
    run_req("sw_104",  1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 1'b0);
    run_req("lw_102",  1'b0, 3'd2, 32'h102, 32'h0, 1'b0);
    run_req("sh_106",  1'b1, 3'd1, 32'h106, 32'h0000_1234, 1'b0);
    run_req("lw_104",  1'b0, 3'd2, 32'h104, 32'h0, 1'b0);
    run_req("sw_101",  1'b1, 3'd2, 32'h101, 32'h5555_5555, 1'b0);
    run_req("sh_103",  1'b1, 3'd1, 32'h103, 32'h5555_5555, 1'b0);
    run_req("st_f3_3", 1'b1, 3'd3, 32'h104, 32'h5555_5555, 1'b0);
    run_req("lb_105",  1'b0, 3'd0, 32'h105, 32'h0, 1'b0);

    check("strobe_protocol", {31'h0, proto_bad}, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_ADDR_WIDTH, 32, number of byte-address bits driven on DMEM_addr_o; upper bits are driven 0.
REQ-002 Port list, one clock and asynchronous active-low reset:
  clk  input  1  rising-edge clock.
  reset_n  input  1  asynchronous reset, active low.
  req_valid_i  input  1  pipeline memory request, sampled only in IDLE.
  req_we_i  input  1  1 = store, 0 = load.
  req_funct3_i  input  3  RV32I width/sign code.
  req_addr_i  input  32  byte address.
  req_wdata_i  input  32  store data, right-aligned.
  busy_o  output  1  request in flight; the pipeline stalls.
  done_o  output  1  one-cycle completion pulse.
  err_o  output  1  misaligned or illegal width, valid with done_o.
  rdata_o  output  32  extended load result, valid with done_o.
  DMEM_addr_o  output  32  word-aligned address.
  DMEM_data_o  output  32  write word.
  DMEM_data_i  input  32  read word, valid one cycle after a DMEM_read_o cycle.
  DMEM_read_o  output  1  read strobe.
  DMEM_write_o  output  1  write strobe, whole word only, no byte enables.

Function
REQ-003 States SHALL be IDLE, RD_ISSUE, RD_DATA, WR, RMW_RD, RMW_DATA, DONE.
REQ-004 When a request is accepted (IDLE with req_valid_i=1), the unit SHALL register addr, funct3, we and wdata.
REQ-005 Transitions out of IDLE on accept:
  loads go to RD_ISSUE.
  SW goes to WR.
  SB and SH go to RMW_RD.
  Misaligned or illegal requests go to DONE with err_o=1.
REQ-006 The unit SHALL flag these cases as misaligned or illegal:
  LH, LHU or SH with addr[0]=1.
  LW or SW with addr[1:0]!=0.
  Load funct3 equal to 3, 6 or 7.
  Store funct3 greater than 2.
REQ-007 In RD_ISSUE and RMW_RD, the unit SHALL drive DMEM_read_o=1 and DMEM_addr_o={addr[31:2],2'b00}, then move to RD_DATA or RMW_DATA.
REQ-008 In RD_DATA, the unit SHALL register the selected lane of DMEM_data_i into rdata_o and go to DONE. Extension rules:
  LB/LH sign-extend.
  LBU/LHU zero-extend.
  The byte lane is addr[1:0]; the halfword lane is addr[1].
REQ-009 In RMW_DATA, the unit SHALL merge wdata[7:0] or wdata[15:0] into the read word at the addressed lane, store the result in the write register, and go to WR.
REQ-010 In WR, the unit SHALL drive DMEM_write_o=1, DMEM_data_o=write register and the aligned address, then go to DONE.
REQ-011 In DONE, done_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-012 busy_o SHALL be 1 in every state except IDLE.
REQ-013 Requests arriving while busy_o=1 SHALL be ignored.
REQ-014 A request presented in the cycle immediately after DONE SHALL be accepted.
REQ-015 Latency from the accept edge to the edge that raises done_o SHALL be:
  load: 3 edges.
  SW: 2 edges.
  SB/SH: 4 edges.
  error: 1 edge.
REQ-016 DMEM_read_o and DMEM_write_o SHALL never be 1 in the same cycle, and both SHALL be 0 outside the states that drive them.
REQ-017 An erroring request SHALL produce no DMEM strobe, and rdata_o SHALL be 0 for it.
REQ-018 rdata_o SHALL hold its value until the next load completes.
REQ-019 DMEM_data_o SHALL be 0 when DMEM_write_o=0.

Reset
REQ-020 reset_n=0 SHALL force state to IDLE immediately, regardless of clk.
REQ-021 Reset SHALL set all outputs and internal registers to 0.
REQ-022 Reset asserted in any state, including mid-RMW, SHALL abort the operation: no later write and no done_o.

Structure
REQ-023 A shared riscv package/include SHALL hold the following:
  funct3 constants LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  The LSU state encoding.
REQ-024 Lane extract and merge SHALL be a combinational sub-module, lsu_align, instantiated once.

Verification
Preload: memory word at 0x100 = 0x8BADF00D.
REQ-025 LB at 0x103 -> rdata_o=0xFFFFFF8B and err_o=0; one DMEM_read_o cycle; done_o 3 edges after accept.
REQ-026 LBU at 0x102 -> 0x000000AD; LHU at 0x102 -> 0x00008BAD; LH at 0x100 -> 0xFFFFF00D.
REQ-027 SB at 0x101 with wdata=0x12345677 -> memory[0x100]=0x8BAD770D; exactly one read then one write; done_o 4 edges after accept.
REQ-028 SW at 0x104 with wdata=0xDEADBEEF -> a single DMEM_write_o cycle with DMEM_addr_o=0x104; done_o 2 edges after accept.
REQ-029 LW at 0x102 -> done_o=1 and err_o=1 one edge after accept; no DMEM strobes; rdata_o=0.
REQ-030 SH at 0x100 with reset_n pulsed low during RMW_DATA -> no DMEM_write_o, no done_o, memory[0x100] still 0x8BADF00D, and all outputs 0.
